// File: rtl/parser_do_parsing.sv
// rtl/parser_do_parsing.sv - RMT parser stage: walks parse actions over captured header bytes into PHV containers.
// One action per cycle; the PHV is assembled on the first OUTPUT cycle and held until phv_ready.
module parser_do_parsing #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_NUM_SEGS         = 16,
    parameter int C_NUM_ACTS         = 24,
    parameter int C_ACT_WIDTH        = 64,
    parameter int C_NUM_CONT         = 8,
    parameter int C_PHV_WIDTH        = 96*8+128
) (
    input  logic                                      axis_clk,
    input  logic                                      aresetn,
    input  logic [C_NUM_SEGS*C_AXIS_DATA_WIDTH-1:0]   segs_in,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]             tuser_in,
    input  logic [C_NUM_ACTS*C_ACT_WIDTH-1:0]         acts_in,
    input  logic                                      segs_valid,
    output logic [C_PHV_WIDTH-1:0]                    phv_out,
    output logic                                      phv_valid,
    input  logic                                      phv_ready,
    output logic                                      parse_err,
    output logic [15:0]                               drop_cnt
);

    localparam int SEGS_W    = C_NUM_SEGS*C_AXIS_DATA_WIDTH;
    localparam int NUM_BYTES = SEGS_W/8;
    localparam int ACTS_W    = C_NUM_ACTS*C_ACT_WIDTH;
    localparam int IDX_W     = $clog2(C_NUM_ACTS);
    localparam int HDR_W     = 20;
    localparam int OFF2      = C_AXIS_TUSER_WIDTH;
    localparam int OFF4      = OFF2 + 16*C_NUM_CONT;
    localparam int OFF6      = OFF4 + 32*C_NUM_CONT;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(C_NUM_ACTS-1);

    typedef enum logic [1:0] {S_IDLE, S_PARSE, S_OUTPUT} state_t;

    state_t                        state_q;
    logic [SEGS_W-1:0]             segs_q;
    logic [C_AXIS_TUSER_WIDTH-1:0] tuser_q;
    logic [HDR_W-1:0]              act_hdr_q [C_NUM_ACTS];
    logic [IDX_W-1:0]              idx_q;
    logic [15:0]                   cont2_q [C_NUM_CONT];
    logic [31:0]                   cont4_q [C_NUM_CONT];
    logic [47:0]                   cont6_q [C_NUM_CONT];
    logic [C_PHV_WIDTH-1:0]        phv_out_q;
    logic [C_PHV_WIDTH-1:0]        phv_d;
    logic                          phv_valid_q;
    logic                          parse_err_q;
    logic [15:0]                   drop_cnt_q;

    // Only the top 20 bits of each action carry meaning; the reserved tail is never stored.
    logic [HDR_W-1:0]      act_hdr_in [C_NUM_ACTS];
    logic [C_NUM_ACTS-1:0] unused_rsvd;
    for (genvar g = 0; g < C_NUM_ACTS; g++) begin : g_act
        assign act_hdr_in[g]  = acts_in[ACTS_W-1-g*C_ACT_WIDTH -: HDR_W];
        assign unused_rsvd[g] = ^acts_in[ACTS_W-1-g*C_ACT_WIDTH-HDR_W -: C_ACT_WIDTH-HDR_W];
    end

    // Six zero pad bytes let the 6-byte window be read at any in-range offset.
    logic [7:0] seg_bytes [NUM_BYTES+6];
    for (genvar g = 0; g < NUM_BYTES; g++) begin : g_byte
        assign seg_bytes[g] = segs_q[8*g +: 8];
    end
    for (genvar g = NUM_BYTES; g < NUM_BYTES+6; g++) begin : g_pad
        assign seg_bytes[g] = 8'h00;
    end

    logic [HDR_W-1:0] act_cur;
    logic             act_valid;
    logic [1:0]       act_size;
    logic [4:0]       act_cont;
    logic [11:0]      act_off;
    logic [12:0]      act_end;
    logic             overrun;
    logic             act_apply;
    logic [9:0]       base;
    logic [47:0]      extr;

    assign act_cur   = act_hdr_q[idx_q];
    assign act_valid = act_cur[19];
    assign act_size  = act_cur[18:17];
    assign act_cont  = act_cur[16:12];
    assign act_off   = act_cur[11:0];

    always_comb begin
        act_end   = {1'b0, act_off} + ((act_size == 2'd0) ? 13'd2 :
                                       (act_size == 2'd1) ? 13'd4 : 13'd6);
        overrun   = act_end > 13'(NUM_BYTES);
        act_apply = act_valid && (act_size != 2'd3) && (act_cont[4:3] == 2'b00);
        base      = overrun ? 10'd0 : act_off[9:0];
        extr      = '0;
        for (int j = 0; j < 6; j++) begin
            extr[47-8*j -: 8] = seg_bytes[base + 10'(j)];
        end
    end

    always_comb begin
        phv_d = '0;
        phv_d[C_AXIS_TUSER_WIDTH-1:0] = tuser_q;
        for (int i = 0; i < C_NUM_CONT; i++) begin
            phv_d[OFF2+16*i +: 16] = cont2_q[i];
            phv_d[OFF4+32*i +: 32] = cont4_q[i];
            phv_d[OFF6+48*i +: 48] = cont6_q[i];
        end
    end

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= S_IDLE;
            segs_q      <= '0;
            tuser_q     <= '0;
            idx_q       <= '0;
            phv_out_q   <= '0;
            phv_valid_q <= 1'b0;
            parse_err_q <= 1'b0;
            drop_cnt_q  <= '0;
            for (int i = 0; i < C_NUM_ACTS; i++) act_hdr_q[i] <= '0;
            for (int i = 0; i < C_NUM_CONT; i++) begin
                cont2_q[i] <= '0;
                cont4_q[i] <= '0;
                cont6_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (segs_valid) begin
                        segs_q      <= segs_in;
                        tuser_q     <= tuser_in;
                        for (int i = 0; i < C_NUM_ACTS; i++) act_hdr_q[i] <= act_hdr_in[i];
                        for (int i = 0; i < C_NUM_CONT; i++) begin
                            cont2_q[i] <= '0;
                            cont4_q[i] <= '0;
                            cont6_q[i] <= '0;
                        end
                        parse_err_q <= 1'b0;
                        idx_q       <= '0;
                        state_q     <= S_PARSE;
                    end
                end
                S_PARSE: begin
                    if (segs_valid && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
                    if (act_apply) begin
                        if (overrun) parse_err_q <= 1'b1;
                        unique case (act_size)
                            2'd0:    cont2_q[act_cont[2:0]] <= overrun ? 16'h0 : extr[47:32];
                            2'd1:    cont4_q[act_cont[2:0]] <= overrun ? 32'h0 : extr[47:16];
                            default: cont6_q[act_cont[2:0]] <= overrun ? 48'h0 : extr;
                        endcase
                    end
                    idx_q <= idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) state_q <= S_OUTPUT;
                end
                default: begin
                    if (!phv_valid_q) begin
                        phv_out_q   <= phv_d;
                        phv_valid_q <= 1'b1;
                        if (segs_valid && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
                    end else if (phv_ready) begin
                        phv_valid_q <= 1'b0;
                        if (segs_valid) begin
                            segs_q      <= segs_in;
                            tuser_q     <= tuser_in;
                            for (int i = 0; i < C_NUM_ACTS; i++) act_hdr_q[i] <= act_hdr_in[i];
                            for (int i = 0; i < C_NUM_CONT; i++) begin
                                cont2_q[i] <= '0;
                                cont4_q[i] <= '0;
                                cont6_q[i] <= '0;
                            end
                            parse_err_q <= 1'b0;
                            idx_q       <= '0;
                            state_q     <= S_PARSE;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else if (segs_valid && drop_cnt_q != 16'hFFFF) begin
                        drop_cnt_q <= drop_cnt_q + 16'd1;
                    end
                end
            endcase
        end
    end

    assign phv_out   = phv_out_q;
    assign phv_valid = phv_valid_q;
    assign parse_err = parse_err_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_parser_do_parsing.sv
// tb/tb_parser_do_parsing.sv - randomized self-checking bench for parser_do_parsing against a byte-level model.
module tb_parser_do_parsing;

    localparam int NB    = 512;
    localparam int NA    = 24;
    localparam int SEGSW = 4096;
    localparam int ACTSW = NA*64;
    localparam int PHVW  = 896;

    logic              axis_clk = 1'b0;
    logic              aresetn;
    logic [SEGSW-1:0]  segs_in;
    logic [127:0]      tuser_in;
    logic [ACTSW-1:0]  acts_in;
    logic              segs_valid;
    logic [PHVW-1:0]   phv_out;
    logic              phv_valid;
    logic              phv_ready;
    logic              parse_err;
    logic [15:0]       drop_cnt;

    parser_do_parsing dut (
        .axis_clk  (axis_clk),
        .aresetn   (aresetn),
        .segs_in   (segs_in),
        .tuser_in  (tuser_in),
        .acts_in   (acts_in),
        .segs_valid(segs_valid),
        .phv_out   (phv_out),
        .phv_valid (phv_valid),
        .phv_ready (phv_ready),
        .parse_err (parse_err),
        .drop_cnt  (drop_cnt)
    );

    always #5 axis_clk = ~axis_clk;

    int n_chk = 0;
    int n_bad = 0;

    logic [7:0]   pkt [NB];
    logic [63:0]  acts [NA];
    logic [127:0] tuser_v;
    logic [15:0]  e_c2 [8];
    logic [31:0]  e_c4 [8];
    logic [47:0]  e_c6 [8];
    logic [127:0] e_tuser;
    logic         e_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk_act(input int v, input int sz, input int cont, input int off);
        logic [63:0] a;
        a = {$urandom(), $urandom()};
        a[63]    = (v != 0);
        a[62:61] = 2'(sz);
        a[60:56] = 5'(cont);
        a[55:44] = 12'(off);
        return a;
    endfunction

    // Reference: walk the action list in order; later writes overwrite earlier ones.
    task automatic model();
        int sz, ci, off, n;
        logic [47:0] val;
        for (int i = 0; i < 8; i++) begin
            e_c2[i] = '0; e_c4[i] = '0; e_c6[i] = '0;
        end
        e_err = 1'b0;
        e_tuser = tuser_v;
        for (int i = 0; i < NA; i++) begin
            if (!acts[i][63]) continue;
            sz  = int'(acts[i][62:61]);
            ci  = int'(acts[i][60:56]);
            off = int'(acts[i][55:44]);
            if (sz == 3 || ci >= 8) continue;
            n = 2*(sz+1);
            val = '0;
            if (off + n > NB) e_err = 1'b1;
            else for (int b = 0; b < n; b++) val = (val << 8) | 48'(pkt[off+b]);
            if (sz == 0) e_c2[ci] = val[15:0];
            else if (sz == 1) e_c4[ci] = val[31:0];
            else e_c6[ci] = val;
        end
    endtask

    task automatic load_inputs();
        for (int k = 0; k < NB; k++) segs_in[8*k +: 8] = pkt[k];
        for (int i = 0; i < NA; i++) acts_in[ACTSW-64-64*i +: 64] = acts[i];
        tuser_in = tuser_v;
    endtask

    task automatic scramble();
        for (int k = 0; k < SEGSW/32; k++) segs_in[32*k +: 32] = $urandom();
        for (int k = 0; k < ACTSW/32; k++) acts_in[32*k +: 32] = $urandom();
        tuser_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic check_phv(input string tag);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s c2[%0d]", tag, i), 64'(phv_out[128+16*i +: 16]), 64'(e_c2[i]));
            chk($sformatf("%s c4[%0d]", tag, i), 64'(phv_out[256+32*i +: 32]), 64'(e_c4[i]));
            chk($sformatf("%s c6[%0d]", tag, i), 64'(phv_out[512+48*i +: 48]), 64'(e_c6[i]));
        end
        chk({tag, " tuser_lo"}, phv_out[63:0], e_tuser[63:0]);
        chk({tag, " tuser_hi"}, phv_out[127:64], e_tuser[127:64]);
        chk({tag, " err"}, 64'(parse_err), 64'(e_err));
    endtask

    task automatic wait_phv(output int lat);
        lat = 0;
        do begin
            @(posedge axis_clk); #1;
            lat++;
        end while (!phv_valid && lat < 60);
    endtask

    task automatic accept(input string tag);
        phv_ready = 1'b1;
        @(posedge axis_clk); #1;
        phv_ready = 1'b0;
        chk({tag, " valid_drop"}, 64'(phv_valid), 64'd0);
    endtask

    task automatic capture();
        load_inputs();
        segs_valid = 1'b1;
        @(posedge axis_clk); #1;
        segs_valid = 1'b0;
        scramble();
    endtask

    task automatic run_pkt(input string tag);
        int lat;
        model();
        capture();
        wait_phv(lat);
        chk({tag, " latency"}, 64'(lat), 64'd25);
        check_phv(tag);
    endtask

    task automatic seq_bytes();
        for (int k = 0; k < NB; k++) pkt[k] = 8'(k);
    endtask

    task automatic rand_bytes();
        for (int k = 0; k < NB; k++) pkt[k] = 8'($urandom());
    endtask

    task automatic clear_acts();
        for (int i = 0; i < NA; i++) acts[i] = mk_act(0, $urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 4095));
    endtask

    task automatic rand_acts();
        int sz, ci, off;
        for (int i = 0; i < NA; i++) begin
            sz  = $urandom_range(0, 3);
            ci  = ($urandom_range(0, 4) == 0) ? $urandom_range(8, 31) : $urandom_range(0, 7);
            off = ($urandom_range(0, 5) == 0) ? $urandom_range(500, 4095) : $urandom_range(0, 505);
            acts[i] = mk_act(($urandom_range(0, 4) != 0) ? 1 : 0, sz, ci, off);
        end
    endtask

    initial begin
        int lat, seen;
        aresetn    = 1'b0;
        segs_valid = 1'b0;
        phv_ready  = 1'b0;
        segs_in    = '0;
        acts_in    = '0;
        tuser_in   = '0;
        repeat (3) @(posedge axis_clk);
        #1;
        chk("rst phv_valid", 64'(phv_valid), 64'd0);
        chk("rst phv_out_nz", 64'(phv_out != '0), 64'd0);
        chk("rst parse_err", 64'(parse_err), 64'd0);
        chk("rst drop_cnt", 64'(drop_cnt), 64'd0);
        aresetn = 1'b1;
        @(posedge axis_clk); #1;

        seq_bytes(); clear_acts();
        acts[0] = mk_act(1, 0, 0, 12);
        tuser_v = {$urandom(), $urandom(), $urandom(), $urandom()};
        run_pkt("single");
        chk("single c2_0 const", 64'(phv_out[128 +: 16]), 64'h0C0D);
        accept("single");

        for (int i = 0; i < NA-1; i++)
            acts[i] = mk_act(1, $urandom_range(0, 2), $urandom_range(0, 7), $urandom_range(0, 505));
        acts[NA-1] = mk_act(1, 2, 7, 506);
        run_pkt("all24");
        chk("all24 c6_7 const", 64'(phv_out[512+48*7 +: 48]), 64'h0000FAFBFCFDFEFF);
        chk("all24 err const", 64'(parse_err), 64'd0);
        accept("all24");

        clear_acts();
        acts[0] = mk_act(1, 2, 2, 0);
        acts[1] = mk_act(1, 2, 2, 508);
        acts[2] = mk_act(1, 0, 1, 510);
        run_pkt("overrun");
        chk("overrun c6_2 const", 64'(phv_out[512+48*2 +: 48]), 64'd0);
        chk("overrun c2_1 const", 64'(phv_out[128+16 +: 16]), 64'hFEFF);
        chk("overrun err const", 64'(parse_err), 64'd1);
        accept("overrun");

        clear_acts();
        acts[3] = mk_act(1, 1, 3, 0);
        acts[9] = mk_act(1, 1, 3, 4);
        run_pkt("dup");
        chk("dup c4_3 const", 64'(phv_out[256+32*3 +: 32]), 64'h04050607);
        chk("dup err cleared", 64'(parse_err), 64'd0);
        accept("dup");

        rand_bytes(); rand_acts();
        tuser_v = {$urandom(), $urandom(), $urandom(), $urandom()};
        model();
        capture();
        lat = 0;
        do begin
            if (lat == 4) segs_valid = 1'b1;
            @(posedge axis_clk); #1;
            segs_valid = 1'b0;
            lat++;
        end while (!phv_valid && lat < 60);
        chk("bp latency", 64'(lat), 64'd25);
        for (int c = 0; c < 10; c++) begin
            if (c == 4) segs_valid = 1'b1;
            @(posedge axis_clk); #1;
            segs_valid = 1'b0;
            chk("bp hold valid", 64'(phv_valid), 64'd1);
            check_phv("bp hold");
        end
        chk("bp drop_cnt", 64'(drop_cnt), 64'd2);
        rand_bytes(); rand_acts();
        tuser_v = {$urandom(), $urandom(), $urandom(), $urandom()};
        model();
        load_inputs();
        segs_valid = 1'b1;
        phv_ready  = 1'b1;
        @(posedge axis_clk); #1;
        segs_valid = 1'b0;
        phv_ready  = 1'b0;
        scramble();
        chk("b2b valid_drop", 64'(phv_valid), 64'd0);
        wait_phv(lat);
        chk("b2b latency", 64'(lat), 64'd25);
        check_phv("b2b");
        chk("b2b drop_cnt", 64'(drop_cnt), 64'd2);
        accept("b2b");

        seq_bytes(); clear_acts();
        acts[0] = mk_act(1, 2, 0, 600);
        acts[5] = mk_act(1, 0, 4, 20);
        capture();
        repeat (10) @(posedge axis_clk);
        #1;
        aresetn = 1'b0;
        #1;
        chk("midrst phv_valid", 64'(phv_valid), 64'd0);
        chk("midrst phv_out_nz", 64'(phv_out != '0), 64'd0);
        chk("midrst parse_err", 64'(parse_err), 64'd0);
        chk("midrst drop_cnt", 64'(drop_cnt), 64'd0);
        repeat (2) @(posedge axis_clk);
        #1;
        aresetn = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge axis_clk); #1;
            if (phv_valid) seen++;
        end
        chk("midrst no phv", 64'(seen), 64'd0);
        rand_bytes(); rand_acts();
        tuser_v = {$urandom(), $urandom(), $urandom(), $urandom()};
        run_pkt("post_rst");
        accept("post_rst");

        for (int p = 0; p < 8; p++) begin
            rand_bytes(); rand_acts();
            tuser_v = {$urandom(), $urandom(), $urandom(), $urandom()};
            run_pkt($sformatf("rnd%0d", p));
            accept($sformatf("rnd%0d", p));
        end
        chk("final drop_cnt", 64'(drop_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
